// File: rtl/ddr3_pkg.sv
// Shared widths and state encoding for the DDR3 write path.
// Imported by the write arbiter, its bus interface and helpers.
package ddr3_pkg;

    localparam int DDR_WORD_ADDR_W = 28;
    localparam int WR_LEN_W        = 8;
    localparam int WR_ID_W         = 4;
    localparam int WR_DATA_W       = 32;
    localparam int WR_STRB_W       = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ddr3_wr_arbiter_if.sv
// Bus bundle between the NUM_M local write masters, the arbiter and ddr3_write.
// Handshake rule for every channel: a transfer happens on a rising clk edge where
// VALID and READY are both 1; VALID never waits on READY, READY may depend on VALID.
interface ddr3_wr_arbiter_if
    import ddr3_pkg::*;
#(
    parameter int NUM_M = 2
) ();

    logic [NUM_M*DDR_WORD_ADDR_W-1:0] M_WR_ADDR;
    logic [NUM_M*WR_LEN_W-1:0]        M_WR_LEN;
    logic [NUM_M*WR_ID_W-1:0]         M_WR_ID;
    logic [NUM_M-1:0]                 M_WR_ADDR_VALID;
    logic [NUM_M-1:0]                 M_WR_ADDR_READY;
    logic [NUM_M*WR_DATA_W-1:0]       M_WR_DATA;
    logic [NUM_M*WR_STRB_W-1:0]       M_WR_STRB;
    logic [NUM_M-1:0]                 M_WR_DATA_VALID;
    logic [NUM_M-1:0]                 M_WR_DATA_LAST;
    logic [NUM_M-1:0]                 M_WR_DATA_READY;
    logic [WR_ID_W-1:0]               M_WR_BACK_ID;
    logic [NUM_M-1:0]                 M_WR_DONE;

    logic [DDR_WORD_ADDR_W-1:0]       WR_ADDR;
    logic [WR_LEN_W-1:0]              WR_LEN;
    logic [WR_ID_W-1:0]               WR_ID;
    logic                             WR_ADDR_VALID;
    logic                             WR_ADDR_READY;
    logic [WR_DATA_W-1:0]             WR_DATA;
    logic [WR_STRB_W-1:0]             WR_STRB;
    logic                             WR_DATA_VALID;
    logic                             WR_DATA_READY;
    logic                             WR_DATA_LAST;
    logic [WR_ID_W-1:0]               WR_BACK_ID;

    modport slave (
        input  M_WR_ADDR, M_WR_LEN, M_WR_ID, M_WR_ADDR_VALID,
        input  M_WR_DATA, M_WR_STRB, M_WR_DATA_VALID, M_WR_DATA_LAST,
        input  WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID,
        output M_WR_ADDR_READY, M_WR_DATA_READY, M_WR_BACK_ID, M_WR_DONE,
        output WR_ADDR, WR_LEN, WR_ID, WR_ADDR_VALID,
        output WR_DATA, WR_STRB, WR_DATA_VALID, WR_DATA_LAST
    );

    modport master (
        output M_WR_ADDR, M_WR_LEN, M_WR_ID, M_WR_ADDR_VALID,
        output M_WR_DATA, M_WR_STRB, M_WR_DATA_VALID, M_WR_DATA_LAST,
        output WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID,
        input  M_WR_ADDR_READY, M_WR_DATA_READY, M_WR_BACK_ID, M_WR_DONE,
        input  WR_ADDR, WR_LEN, WR_ID, WR_ADDR_VALID,
        input  WR_DATA, WR_STRB, WR_DATA_VALID, WR_DATA_LAST
    );

endinterface

// File: rtl/ddr3_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after 'last',
// wrapping modulo NUM_M. Shared by the write arbiter and a future read arbiter.
module rr_pick #(
    parameter int NUM_M = 2,
    parameter int GW    = 3
) (
    input  logic [NUM_M-1:0] req,
    input  logic [GW-1:0]    last,
    output logic             any,
    output logic [GW-1:0]    idx
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NUM_M; k >= 1; k--) begin
            for (int j = 0; j < NUM_M; j++) begin
                if (req[j] && (j == ((int'(last) + k) % NUM_M))) begin
                    any = 1'b1;
                    idx = GW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ddr3_wr_arbiter.sv
// Round-robin write arbiter in front of ddr3_write: grants one complete burst
// (address then every data beat up to LAST) to one local master at a time.
module ddr3_wr_arbiter
    import ddr3_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int GW    = 3
) (
    input  logic               clk,
    input  logic               rstn,
    ddr3_wr_arbiter_if.slave   bus,
    output logic               WR_ERR,
    output logic [GW-1:0]      GRANT_IDX,
    output arb_state_e         arb_state
);

    arb_state_e                 state_q, state_d;
    logic [GW-1:0]              grant_q;
    logic [GW-1:0]              last_grant_q;
    logic [WR_LEN_W-1:0]        beat_cnt_q;
    logic [WR_LEN_W-1:0]        len_q;
    logic [NUM_M-1:0]           done_q;
    logic                       err_q;

    logic                       pick_any;
    logic [GW-1:0]              pick_idx;

    logic [NUM_M-1:0]           grant_oh;
    logic [DDR_WORD_ADDR_W-1:0] g_addr;
    logic [WR_LEN_W-1:0]        g_len;
    logic [WR_ID_W-1:0]         g_id;
    logic                       g_av;
    logic [WR_DATA_W-1:0]       g_data;
    logic [WR_STRB_W-1:0]       g_strb;
    logic                       g_dv;
    logic                       g_last;
    logic                       addr_hs;
    logic                       data_hs;

    rr_pick #(
        .NUM_M (NUM_M),
        .GW    (GW)
    ) u_pick (
        .req  (bus.M_WR_ADDR_VALID),
        .last (last_grant_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Select the granted master's channels; indices compared as constants per lane.
    always_comb begin
        grant_oh = '0;
        g_addr   = '0;
        g_len    = '0;
        g_id     = '0;
        g_av     = 1'b0;
        g_data   = '0;
        g_strb   = '0;
        g_dv     = 1'b0;
        g_last   = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q == GW'(i)) begin
                grant_oh[i] = 1'b1;
                g_addr      = bus.M_WR_ADDR[i*DDR_WORD_ADDR_W +: DDR_WORD_ADDR_W];
                g_len       = bus.M_WR_LEN[i*WR_LEN_W +: WR_LEN_W];
                g_id        = bus.M_WR_ID[i*WR_ID_W +: WR_ID_W];
                g_av        = bus.M_WR_ADDR_VALID[i];
                g_data      = bus.M_WR_DATA[i*WR_DATA_W +: WR_DATA_W];
                g_strb      = bus.M_WR_STRB[i*WR_STRB_W +: WR_STRB_W];
                g_dv        = bus.M_WR_DATA_VALID[i];
                g_last      = bus.M_WR_DATA_LAST[i];
            end
        end
    end

    assign addr_hs = (state_q == ARB_ADDR) && g_av && bus.WR_ADDR_READY;
    assign data_hs = (state_q == ARB_DATA) && g_dv && bus.WR_DATA_READY;

    always_comb begin
        state_d             = state_q;
        bus.WR_ADDR         = g_addr;
        bus.WR_LEN          = g_len;
        bus.WR_ID           = g_id;
        bus.WR_DATA         = g_data;
        bus.WR_STRB         = g_strb;
        bus.WR_DATA_LAST    = g_last;
        bus.WR_ADDR_VALID   = 1'b0;
        bus.WR_DATA_VALID   = 1'b0;
        bus.M_WR_ADDR_READY = '0;
        bus.M_WR_DATA_READY = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) state_d = ARB_ADDR;
            end
            ARB_ADDR: begin
                // A master that withdraws its request keeps the grant; no re-arbitration.
                bus.WR_ADDR_VALID   = g_av;
                bus.M_WR_ADDR_READY = grant_oh & {NUM_M{bus.WR_ADDR_READY}};
                if (addr_hs) state_d = ARB_DATA;
            end
            ARB_DATA: begin
                bus.WR_DATA_VALID   = g_dv;
                bus.M_WR_DATA_READY = grant_oh & {NUM_M{bus.WR_DATA_READY}};
                if (data_hs && g_last) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_M - 1);
            beat_cnt_q   <= '0;
            len_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= '0;
            if ((state_q == ARB_IDLE) && pick_any) grant_q <= pick_idx;
            if (addr_hs) begin
                len_q      <= g_len;
                beat_cnt_q <= '0;
            end
            // Length mismatches are only flagged; the burst always runs to LAST.
            if (data_hs) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
                if (g_last) begin
                    done_q       <= grant_oh;
                    last_grant_q <= grant_q;
                    if (beat_cnt_q != len_q) err_q <= 1'b1;
                end else if (beat_cnt_q == len_q) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.M_WR_DONE    = done_q;
    assign bus.M_WR_BACK_ID = bus.WR_BACK_ID;
    assign WR_ERR           = err_q;
    assign GRANT_IDX        = grant_q;
    assign arb_state        = state_q;

endmodule

// File: tb/tb_ddr3_wr_arbiter.sv
// Directed bench for ddr3_wr_arbiter: cycle table for single/errored bursts plus
// hand sequences for reset mid-burst, two-master contention and backpressure.
module tb_ddr3_wr_arbiter;
    import ddr3_pkg::*;

    localparam int NUM_M = 2;
    localparam int GW    = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            wr_err;
    logic [GW-1:0]   grant_idx;
    arb_state_e      arb_state;

    logic [27:0]      m_addr [NUM_M];
    logic [7:0]       m_len  [NUM_M];
    logic [3:0]       m_id   [NUM_M];
    logic [31:0]      m_data [NUM_M];
    logic [NUM_M-1:0] m_av;
    logic [NUM_M-1:0] m_dv;
    logic [NUM_M-1:0] m_dl;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    int          exp_done_q[$];

    always #5 clk = ~clk;

    ddr3_wr_arbiter_if #(.NUM_M(NUM_M)) bus ();

    ddr3_wr_arbiter #(
        .NUM_M (NUM_M),
        .GW    (GW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .WR_ERR    (wr_err),
        .GRANT_IDX (grant_idx),
        .arb_state (arb_state)
    );

    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_pack
        assign bus.M_WR_ADDR[gi*28 +: 28] = m_addr[gi];
        assign bus.M_WR_LEN[gi*8 +: 8]    = m_len[gi];
        assign bus.M_WR_ID[gi*4 +: 4]     = m_id[gi];
        assign bus.M_WR_DATA[gi*32 +: 32] = m_data[gi];
    end
    assign bus.M_WR_STRB       = '1;
    assign bus.M_WR_ADDR_VALID = m_av;
    assign bus.M_WR_DATA_VALID = m_dv;
    assign bus.M_WR_DATA_LAST  = m_dl;

    typedef struct {
        logic [1:0]  av;
        logic [1:0]  dv;
        logic [1:0]  dl;
        logic        dr;
        logic [31:0] d0;
        logic        e_av;
        logic [27:0] e_addr;
        logic        e_dv;
        logic        e_dl;
        logic [31:0] e_wd;
        logic [1:0]  e_mar;
        logic [1:0]  e_mdr;
        logic [1:0]  e_done;
        logic [2:0]  e_g;
        logic        e_err;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input int i, input int b, input int k);
        return {4'(i + 1), 20'h0, 4'(b), 4'(k)};
    endfunction

    task automatic drive(input logic [1:0] av, input logic [1:0] dv, input logic [1:0] dl,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(posedge clk);
        #1;
        m_av      = av;
        m_dv      = dv;
        m_dl      = dl;
        m_data[0] = d0;
        m_data[1] = d1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        m_av = '0;
        m_dv = '0;
        m_dl = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Both masters behave as real masters: count their own accepted beats and
    // raise LAST when the beat count reaches their LEN.
    task automatic run_bursts(input logic [1:0] mask, input int per_m, input bit bp);
        int beat [NUM_M];
        int bno  [NUM_M];
        int cyc;
        int done_seen;
        int total;
        int pi;
        int eg;
        logic [3:0]  pat;
        logic [31:0] e;
        logic [1:0]  exp_mdr;
        beat      = '{0, 0};
        bno       = '{0, 0};
        cyc       = 0;
        done_seen = 0;
        pi        = 0;
        pat       = 4'b1001;
        total     = per_m * ((mask[0] ? 1 : 0) + (mask[1] ? 1 : 0));
        while (done_seen < total && cyc < 300) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_M; i++) begin
                m_av[i]   = mask[i] && (bno[i] < per_m);
                m_dv[i]   = mask[i] && (bno[i] < per_m);
                m_data[i] = mk_data(i, bno[i], beat[i]);
                m_dl[i]   = (beat[i] == int'(m_len[i]));
            end
            bus.WR_DATA_READY = bp ? pat[pi % 4] : 1'b1;
            pi++;
            @(negedge clk);
            cyc++;
            if (bus.WR_DATA_VALID) begin
                eg      = (exp_q.size() > 0) ? int'(exp_q[0][31:28]) - 1 : 0;
                exp_mdr = bus.WR_DATA_READY ? (2'b01 << eg) : 2'b00;
                check("m_data_ready_mirror", 32'(bus.M_WR_DATA_READY), 32'(exp_mdr));
            end
            if (bus.WR_DATA_VALID && bus.WR_DATA_READY) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", bus.WR_DATA, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", bus.WR_DATA, e);
                    check("beat_grant", 32'(grant_idx), 32'(int'(e[31:28]) - 1));
                end
            end
            for (int i = 0; i < NUM_M; i++) begin
                if (m_dv[i] && bus.M_WR_DATA_READY[i]) begin
                    if (m_dl[i]) begin
                        beat[i] = 0;
                        bno[i]++;
                    end else begin
                        beat[i]++;
                    end
                end
            end
            if (bus.M_WR_DONE != '0) begin
                done_seen++;
                if (exp_done_q.size() > 0) begin
                    eg = exp_done_q.pop_front();
                    check("done_onehot", 32'(bus.M_WR_DONE), 32'(2'b01 << eg));
                end else begin
                    check("unexpected_done", 32'(bus.M_WR_DONE), 32'h0);
                end
            end
        end
        check("burst_timeout", done_seen, total);
        check("beats_left", exp_q.size(), 0);
        m_av = '0;
        m_dv = '0;
        m_dl = '0;
        bus.WR_DATA_READY = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // av, dv, dl, dr, d0 | e_av, e_addr, e_dv, e_dl, e_wd, e_mar, e_mdr, e_done, e_g, e_err
        tbl[0]  = '{2'b00, 2'b10, 2'b10, 1'b1, 32'h0,  1'b0, 28'h0,  1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b00, 3'd0, 1'b0};
        tbl[1]  = '{2'b01, 2'b10, 2'b10, 1'b1, 32'h0,  1'b0, 28'h0,  1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b00, 3'd0, 1'b0};
        tbl[2]  = '{2'b01, 2'b10, 2'b10, 1'b1, 32'h0,  1'b1, 28'h10, 1'b0, 1'b0, 32'h0,  2'b01, 2'b00, 2'b00, 3'd0, 1'b0};
        tbl[3]  = '{2'b00, 2'b11, 2'b10, 1'b1, 32'hA0, 1'b0, 28'h0,  1'b1, 1'b0, 32'hA0, 2'b00, 2'b01, 2'b00, 3'd0, 1'b0};
        tbl[4]  = '{2'b00, 2'b11, 2'b10, 1'b1, 32'hA1, 1'b0, 28'h0,  1'b1, 1'b0, 32'hA1, 2'b00, 2'b01, 2'b00, 3'd0, 1'b0};
        tbl[5]  = '{2'b00, 2'b11, 2'b10, 1'b1, 32'hA2, 1'b0, 28'h0,  1'b1, 1'b0, 32'hA2, 2'b00, 2'b01, 2'b00, 3'd0, 1'b0};
        tbl[6]  = '{2'b00, 2'b11, 2'b11, 1'b1, 32'hA3, 1'b0, 28'h0,  1'b1, 1'b1, 32'hA3, 2'b00, 2'b01, 2'b00, 3'd0, 1'b0};
        tbl[7]  = '{2'b00, 2'b10, 2'b10, 1'b1, 32'h0,  1'b0, 28'h0,  1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b01, 3'd0, 1'b0};
        tbl[8]  = '{2'b00, 2'b10, 2'b10, 1'b1, 32'h0,  1'b0, 28'h0,  1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b00, 3'd0, 1'b0};
        tbl[9]  = '{2'b01, 2'b10, 2'b10, 1'b1, 32'h0,  1'b0, 28'h0,  1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b00, 3'd0, 1'b0};
        tbl[10] = '{2'b01, 2'b10, 2'b10, 1'b1, 32'h0,  1'b1, 28'h10, 1'b0, 1'b0, 32'h0,  2'b01, 2'b00, 2'b00, 3'd0, 1'b0};
        tbl[11] = '{2'b00, 2'b11, 2'b10, 1'b1, 32'hB0, 1'b0, 28'h0,  1'b1, 1'b0, 32'hB0, 2'b00, 2'b01, 2'b00, 3'd0, 1'b0};
        tbl[12] = '{2'b00, 2'b11, 2'b11, 1'b1, 32'hB1, 1'b0, 28'h0,  1'b1, 1'b1, 32'hB1, 2'b00, 2'b01, 2'b00, 3'd0, 1'b0};
        tbl[13] = '{2'b00, 2'b10, 2'b10, 1'b1, 32'h0,  1'b0, 28'h0,  1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b01, 3'd0, 1'b1};
        tbl[14] = '{2'b01, 2'b10, 2'b10, 1'b1, 32'h0,  1'b0, 28'h0,  1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b00, 3'd0, 1'b1};
        tbl[15] = '{2'b01, 2'b10, 2'b10, 1'b1, 32'h0,  1'b1, 28'h10, 1'b0, 1'b0, 32'h0,  2'b01, 2'b00, 2'b00, 3'd0, 1'b1};
        tbl[16] = '{2'b00, 2'b11, 2'b10, 1'b1, 32'hC0, 1'b0, 28'h0,  1'b1, 1'b0, 32'hC0, 2'b00, 2'b01, 2'b00, 3'd0, 1'b1};
        tbl[17] = '{2'b00, 2'b11, 2'b10, 1'b1, 32'hC1, 1'b0, 28'h0,  1'b1, 1'b0, 32'hC1, 2'b00, 2'b01, 2'b00, 3'd0, 1'b1};
        tbl[18] = '{2'b00, 2'b11, 2'b10, 1'b1, 32'hC2, 1'b0, 28'h0,  1'b1, 1'b0, 32'hC2, 2'b00, 2'b01, 2'b00, 3'd0, 1'b1};
        tbl[19] = '{2'b00, 2'b11, 2'b11, 1'b1, 32'hC3, 1'b0, 28'h0,  1'b1, 1'b1, 32'hC3, 2'b00, 2'b01, 2'b00, 3'd0, 1'b1};
        tbl[20] = '{2'b00, 2'b10, 2'b10, 1'b1, 32'h0,  1'b0, 28'h0,  1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b01, 3'd0, 1'b1};

        rstn              = 1'b0;
        m_addr[0]         = 28'h0000010;
        m_addr[1]         = 28'h0000020;
        m_len[0]          = 8'd3;
        m_len[1]          = 8'd1;
        m_id[0]           = 4'h1;
        m_id[1]           = 4'h2;
        m_data[0]         = '0;
        m_data[1]         = 32'hDEADBEEF;
        m_av              = '0;
        m_dv              = '0;
        m_dl              = '0;
        bus.WR_ADDR_READY = 1'b1;
        bus.WR_DATA_READY = 1'b1;
        bus.WR_BACK_ID    = 4'hA;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("back_id_a", 32'(bus.M_WR_BACK_ID), 32'hA);
        bus.WR_BACK_ID = 4'h3;
        #1;
        check("back_id_3", 32'(bus.M_WR_BACK_ID), 32'h3);
        check("reset_state", 32'(arb_state), 32'(ARB_IDLE));

        // Single burst, length error, then a clean burst with the error still sticky.
        for (int n = 0; n < 21; n++) begin
            bus.WR_DATA_READY = tbl[n].dr;
            drive(tbl[n].av, tbl[n].dv, tbl[n].dl, tbl[n].d0, 32'hDEADBEEF);
            check($sformatf("v%0d.addr_valid", n), 32'(bus.WR_ADDR_VALID), 32'(tbl[n].e_av));
            check($sformatf("v%0d.data_valid", n), 32'(bus.WR_DATA_VALID), 32'(tbl[n].e_dv));
            check($sformatf("v%0d.m_addr_ready", n), 32'(bus.M_WR_ADDR_READY), 32'(tbl[n].e_mar));
            check($sformatf("v%0d.m_data_ready", n), 32'(bus.M_WR_DATA_READY), 32'(tbl[n].e_mdr));
            check($sformatf("v%0d.done", n), 32'(bus.M_WR_DONE), 32'(tbl[n].e_done));
            check($sformatf("v%0d.grant", n), 32'(grant_idx), 32'(tbl[n].e_g));
            check($sformatf("v%0d.err", n), 32'(wr_err), 32'(tbl[n].e_err));
            if (tbl[n].e_av) begin
                check($sformatf("v%0d.addr", n), 32'(bus.WR_ADDR), 32'(tbl[n].e_addr));
            end
            if (tbl[n].e_dv) begin
                check($sformatf("v%0d.wdata", n), bus.WR_DATA, tbl[n].e_wd);
                check($sformatf("v%0d.wlast", n), 32'(bus.WR_DATA_LAST), 32'(tbl[n].e_dl));
            end
        end

        // Reset after the second beat of an 8-beat burst.
        m_len[0] = 8'd7;
        drive(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
        drive(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
        check("rst_seq.addr_valid", 32'(bus.WR_ADDR_VALID), 32'h1);
        drive(2'b00, 2'b01, 2'b00, 32'hD0, 32'h0);
        check("rst_seq.beat0", bus.WR_DATA, 32'hD0);
        drive(2'b00, 2'b01, 2'b00, 32'hD1, 32'h0);
        check("rst_seq.beat1", bus.WR_DATA, 32'hD1);
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        m_data[0] = 32'hD2;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_dv = '0;
        @(negedge clk);
        check("post_rst.addr_valid", 32'(bus.WR_ADDR_VALID), 32'h0);
        check("post_rst.data_valid", 32'(bus.WR_DATA_VALID), 32'h0);
        check("post_rst.m_addr_ready", 32'(bus.M_WR_ADDR_READY), 32'h0);
        check("post_rst.m_data_ready", 32'(bus.M_WR_DATA_READY), 32'h0);
        check("post_rst.done", 32'(bus.M_WR_DONE), 32'h0);
        check("post_rst.err", 32'(wr_err), 32'h0);
        check("post_rst.grant", 32'(grant_idx), 32'h0);
        check("post_rst.state", 32'(arb_state), 32'(ARB_IDLE));

        // Master 1 alone, overrunning its LEN=1 by one beat.
        drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h0);
        check("m1_req.done", 32'(bus.M_WR_DONE), 32'h0);
        check("m1_req.addr_valid", 32'(bus.WR_ADDR_VALID), 32'h0);
        drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h0);
        check("m1_grant.addr_valid", 32'(bus.WR_ADDR_VALID), 32'h1);
        check("m1_grant.grant", 32'(grant_idx), 32'h1);
        check("m1_grant.m_addr_ready", 32'(bus.M_WR_ADDR_READY), 32'h2);
        check("m1_grant.addr", 32'(bus.WR_ADDR), 32'h20);
        check("m1_grant.len", 32'(bus.WR_LEN), 32'h1);
        check("m1_grant.id", 32'(bus.WR_ID), 32'h2);
        drive(2'b00, 2'b10, 2'b00, 32'h0, 32'hE0);
        check("m1_beat0", bus.WR_DATA, 32'hE0);
        check("m1_beat0.m_data_ready", 32'(bus.M_WR_DATA_READY), 32'h2);
        drive(2'b00, 2'b10, 2'b00, 32'h0, 32'hE1);
        check("m1_beat1", bus.WR_DATA, 32'hE1);
        check("m1_beat1.err", 32'(wr_err), 32'h0);
        drive(2'b00, 2'b10, 2'b10, 32'h0, 32'hE2);
        check("m1_beat2", bus.WR_DATA, 32'hE2);
        check("m1_overrun.err", 32'(wr_err), 32'h1);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        check("m1_done", 32'(bus.M_WR_DONE), 32'h2);

        // Contention: both masters request continuously, grants alternate from master 0.
        do_reset();
        m_len[0] = 8'd1;
        m_len[1] = 8'd1;
        for (int b = 0; b < 2; b++) begin
            for (int m = 0; m < NUM_M; m++) begin
                for (int k = 0; k < 2; k++) exp_q.push_back(mk_data(m, b, k));
                exp_done_q.push_back(m);
            end
        end
        run_bursts(2'b11, 2, 1'b0);
        check("contention.err", 32'(wr_err), 32'h0);

        // Backpressure on an 8-beat burst.
        m_len[0] = 8'd7;
        for (int k = 0; k < 8; k++) exp_q.push_back(mk_data(0, 0, k));
        exp_done_q.push_back(0);
        run_bursts(2'b01, 1, 1'b1);
        check("backpressure.err", 32'(wr_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr3_wr_arbiter.md
Name: ddr3_wr_arbiter

Overview:
- Write-path arbiter directly upstream of ddr3_write. It accepts 32-bit burst write requests from NUM_M local masters (camera/UART/JTAG bridges).
- Grants one whole burst (address plus all data beats up to LAST) at a time, round-robin, and forwards it on the WR_* channel of ddr3_write.
- Returns a per-master completion pulse and a sticky protocol-error flag.

Parameters:
- NUM_M, 2, number of upstream masters (1..8).
- GW, 3, grant index width; must satisfy 2**GW >= NUM_M.

Ports:
- clk  in  1  single system clock.
- rstn  in  1  synchronous active-low reset.
- M_WR_ADDR  in  NUM_M*28  per-master start address in 32-bit words; master i at bits [28i+27:28i].
- M_WR_LEN  in  NUM_M*8  per-master beats-1.
- M_WR_ID  in  NUM_M*4  per-master transaction ID.
- M_WR_ADDR_VALID  in  NUM_M  per-master address request.
- M_WR_ADDR_READY  out  NUM_M  address accepted; only the granted bit can be 1.
- M_WR_DATA  in  NUM_M*32  per-master write data.
- M_WR_STRB  in  NUM_M*4  per-master byte strobes.
- M_WR_DATA_VALID  in  NUM_M  per-master data valid.
- M_WR_DATA_LAST  in  NUM_M  per-master last beat.
- M_WR_DATA_READY  out  NUM_M  data accepted; only the granted bit can be 1.
- M_WR_BACK_ID  out  4  broadcast copy of WR_BACK_ID.
- M_WR_DONE  out  NUM_M  one-cycle pulse when that master's LAST beat is accepted.
- WR_ADDR  out  28  to ddr3_write.
- WR_LEN  out  8  to ddr3_write.
- WR_ID  out  4  to ddr3_write.
- WR_ADDR_VALID  out  1  to ddr3_write.
- WR_ADDR_READY  in  1  from ddr3_write.
- WR_DATA  out  32  to ddr3_write.
- WR_STRB  out  4  to ddr3_write.
- WR_DATA_VALID  out  1  to ddr3_write.
- WR_DATA_READY  in  1  from ddr3_write.
- WR_DATA_LAST  out  1  to ddr3_write.
- WR_BACK_ID  in  4  from ddr3_write.
- WR_ERR  out  1  sticky: LAST position disagreed with LEN.
- GRANT_IDX  out  GW  currently granted master, for debug.

Behaviour:
- Reset (rstn=0 at clk edge) values:
  - State=IDLE, last_grant=NUM_M-1 so master 0 wins first, beat_cnt=0, WR_ERR=0, GRANT_IDX=0.
  - All VALID/READY/DONE outputs are 0.
  - Reset mid-burst abandons the burst immediately; no DONE pulse.
- State IDLE:
  - All M_*_READY=0 and WR_ADDR_VALID=0.
  - If any M_WR_ADDR_VALID is set, pick the first requesting index after last_grant, wrapping modulo NUM_M.
  - Register it as GRANT_IDX and move to ADDR. Arbitration latency is exactly 1 cycle.
- State ADDR:
  - WR_ADDR/LEN/ID and WR_ADDR_VALID are combinational muxes of the granted master's signals.
  - M_WR_ADDR_READY[g]=WR_ADDR_READY.
  - On handshake (valid and ready): latch len_q=WR_LEN, clear beat_cnt, go to DATA.
  - If the granted master drops ADDR_VALID before the handshake, stay in ADDR and keep the grant; there is no re-arbitration.
- State DATA:
  - WR_DATA/STRB/LAST and WR_DATA_VALID mux the granted master's data channel.
  - M_WR_DATA_READY[g]=WR_DATA_READY; WR_ADDR_VALID=0.
  - Each accepted beat increments beat_cnt (8-bit).
  - When an accepted beat has LAST=1:
    - pulse M_WR_DONE[g] on the next cycle;
    - set last_grant=g;
    - go to IDLE.
- Same-cycle request and completion: a request arriving while DONE pulses is arbitrated in the following IDLE cycle. Minimum gap between bursts is 2 cycles (DONE/IDLE, then grant).
- Error checks, which never alter flow:
  - LAST accepted with beat_cnt != len_q sets WR_ERR.
  - Beat accepted with beat_cnt == len_q and LAST=0 sets WR_ERR; keep accepting until LAST.
- Ungranted masters always see READY=0 and their inputs are ignored.
- M_WR_BACK_ID=WR_BACK_ID, combinational.
- The arbiter performs no address or length arithmetic; word alignment is handled by ddr3_write.

Decomposition:
- ddr3_pkg holds:
  - widths: DDR_WORD_ADDR_W=28, WR_LEN_W=8, WR_ID_W=4;
  - the state encoding ARB_IDLE/ARB_ADDR/ARB_DATA.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req[NUM_M], last[GW].
  - Outputs: any, idx[GW].
  - Reusable for a future read arbiter.

Test Plan:
- Single burst: master0 requests ADDR=0x0000010, LEN=3 with 4 beats 0xA0..0xA3, ddr3_write always ready.
  - WR_ADDR_VALID rises 1 cycle after request.
  - WR_DATA carries 4 beats with LAST on 0xA3.
  - M_WR_DONE[0] pulses once; WR_ERR=0.
- Contention: masters 0 and 1 both request continuously, LEN=1.
  - Grants alternate 0,1,0,1 over four bursts.
  - GRANT_IDX matches; no beat of master1 appears during master0's burst.
- Backpressure: WR_DATA_READY toggles 1,0,0,1 during an 8-beat burst (LEN=7).
  - Exactly 8 beats forwarded in order, no duplication.
  - M_WR_DATA_READY[g] mirrors WR_DATA_READY.
- Length error: LEN=3 but LAST on 2nd beat.
  - Burst ends after 2 beats and DONE pulses.
  - WR_ERR=1 and stays 1 over the next clean burst.
- Reset mid-burst: rstn=0 for 1 cycle after beat 2 of LEN=7.
  - All outputs 0 next cycle, no DONE.
  - Next request from master1 alone is granted within 1 cycle.
